// File: rtl/clock_disp_pkg.sv
// Shared constants, payload type and digit pattern table for the 6-digit clock display scanner.
package clock_disp_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SLOT_W     = 3;

  // Active-high {g,f,e,d,c,b,a} patterns; polarity is applied at the output register.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

  localparam logic [SLOT_W-1:0] SLOT_HT = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_HU = 3'd1;
  localparam logic [SLOT_W-1:0] SLOT_MT = 3'd2;
  localparam logic [SLOT_W-1:0] SLOT_MU = 3'd3;
  localparam logic [SLOT_W-1:0] SLOT_ST = 3'd4;
  localparam logic [SLOT_W-1:0] SLOT_SU = 3'd5;

  localparam logic [9:0][SEG_W-1:0] DIGIT_PAT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } time_bcd_t;

endpackage

// File: rtl/bcd_to_7seg_sar.sv
// Combinational BCD nibble to active-high 7-segment decoder; non-decimal nibbles show a dash.
module bcd_to_7seg_sar
  import clock_disp_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (nibble_i <= 4'd9) begin
      seg_o = DIGIT_PAT[nibble_i];
    end
  end

endmodule

// File: rtl/clock_display_scan_sar.sv
// Time-multiplexed 6-digit 7-seg scanner for packed-BCD hh:mm:ss with per-frame snapshotting.
module clock_display_scan_sar
  import clock_disp_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          LZ_BLANK       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [7:0]            hour,
  input  logic [7:0]            min,
  input  logic [7:0]            sec,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_start
);

  localparam int unsigned          PRESC_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [SEG_W-1:0]     SEG_OFF   = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic                 DP_OFF    = SEG_ACTIVE_LOW;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  fresh_q, fresh_d;
  time_bcd_t             snap_q, snap_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  fs_q, fs_d;

  logic [3:0]            nibble_c;
  logic [SEG_W-1:0]      pat_c;
  logic [SEG_W-1:0]      lit_c;
  logic                  dp_lit_c;

  // Pick the snapshot nibble for the slot currently being scanned.
  always_comb begin
    nibble_c = snap_q.sec[3:0];
    case (slot_q)
      SLOT_HT: nibble_c = snap_q.hour[7:4];
      SLOT_HU: nibble_c = snap_q.hour[3:0];
      SLOT_MT: nibble_c = snap_q.min[7:4];
      SLOT_MU: nibble_c = snap_q.min[3:0];
      SLOT_ST: nibble_c = snap_q.sec[7:4];
      default: nibble_c = snap_q.sec[3:0];
    endcase
  end

  bcd_to_7seg_sar u_dec (
    .nibble_i (nibble_c),
    .seg_o    (pat_c)
  );

  // Leading-zero blanking keeps the digit enable, only the segments go dark.
  always_comb begin
    lit_c = pat_c;
    if (LZ_BLANK && (slot_q == SLOT_HT) && (snap_q.hour[7:4] == 4'd0)) begin
      lit_c = SEG_BLANK;
    end
    dp_lit_c = ((slot_q == SLOT_HU) || (slot_q == SLOT_MU)) && !snap_q.sec[0];
  end

  always_comb begin
    presc_d = presc_q;
    slot_d  = slot_q;
    fresh_d = fresh_q;
    snap_d  = snap_q;
    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    dig_d   = '0;
    fs_d    = 1'b0;

    if (!en) begin
      presc_d = '0;
      slot_d  = SLOT_HT;
      fresh_d = 1'b1;
    end else if (fresh_q) begin
      snap_d  = '{hour: hour, min: min, sec: sec};
      fresh_d = 1'b0;
      fs_d    = 1'b1;
    end else begin
      seg_d = SEG_ACTIVE_LOW ? ~lit_c : lit_c;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_lit_c : dp_lit_c;
      dig_d = NUM_DIGITS'(1) << slot_q;
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (slot_q == SLOT_SU) begin
          slot_d = SLOT_HT;
          snap_d = '{hour: hour, min: min, sec: sec};
          fs_d   = 1'b1;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      slot_q  <= SLOT_HT;
      fresh_q <= 1'b1;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      dig_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      fresh_q <= fresh_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
      fs_q    <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign dig_sel     = dig_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_clock_display_scan_sar.sv
// Directed plus randomized bench for clock_display_scan_sar against a cycle-count display model.
module tb_clock_display_scan_sar;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] hour, min, sec;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [5:0] dig0, dig1;
  logic       fs0, fs1;

  always #5 clk = ~clk;

  clock_display_scan_sar #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hour(hour), .min(min), .sec(sec),
    .seg(seg0), .dp(dp0), .dig_sel(dig0), .frame_start(fs0)
  );

  clock_display_scan_sar #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .en(en), .hour(hour), .min(min), .sec(sec),
    .seg(seg1), .dp(dp1), .dig_sel(dig1), .frame_start(fs1)
  );

  // Active-low segment codes for digits 0..9 written from the display's point of view.
  logic [6:0] exp_digit [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int n_pass  = 0;
  int n_total = 0;

  // Model: snapshot digits, a freshness flag and the number of scan cycles since the last load.
  logic       m_fresh = 1'b1;
  int         m_cnt   = 0;
  logic [3:0] m_snap [6];
  logic [6:0] e_seg, e_seg_lz;
  logic       e_dp, e_fs;
  logic [5:0] e_dig;

  task automatic capture();
    m_snap[0] = hour[7:4]; m_snap[1] = hour[3:0];
    m_snap[2] = min[7:4];  m_snap[3] = min[3:0];
    m_snap[4] = sec[7:4];  m_snap[5] = sec[3:0];
  endtask

  task automatic model_edge();
    int slot;
    e_seg = 7'h7F; e_seg_lz = 7'h7F; e_dp = 1'b1; e_dig = '0; e_fs = 1'b0;
    if (!rst_n) begin
      m_fresh = 1'b1; m_cnt = 0;
      for (int i = 0; i < 6; i++) m_snap[i] = '0;
    end else if (!en) begin
      m_fresh = 1'b1; m_cnt = 0;
    end else if (m_fresh) begin
      capture();
      m_fresh = 1'b0; m_cnt = 0; e_fs = 1'b1;
    end else begin
      slot     = (m_cnt / 4) % 6;
      e_dig    = 6'(1 << slot);
      e_seg    = (m_snap[slot] > 4'd9) ? 7'h3F : exp_digit[m_snap[slot]];
      e_seg_lz = (slot == 0 && m_snap[0] == 4'd0) ? 7'h7F : e_seg;
      e_dp     = ((slot == 1 || slot == 3) && !m_snap[5][0]) ? 1'b0 : 1'b1;
      if ((m_cnt % 24) == 23) begin
        e_fs = 1'b1;
        capture();
      end
      m_cnt++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("seg",         32'(seg0), 32'(e_seg));
    check("dp",          32'(dp0),  32'(e_dp));
    check("dig_sel",     32'(dig0), 32'(e_dig));
    check("frame_start", 32'(fs0),  32'(e_fs));
    check("lz_seg",      32'(seg1), 32'(e_seg_lz));
    check("lz_dp",       32'(dp1),  32'(e_dp));
    check("lz_dig_sel",  32'(dig1), 32'(e_dig));
    check("lz_fs",       32'(fs1),  32'(e_fs));
  endtask

  function automatic logic [7:0] rand_bcd();
    logic [3:0] t, u;
    t = 4'($urandom_range(0, 11));
    u = 4'($urandom_range(0, 11));
    return {t, u};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; hour = '0; min = '0; sec = '0;

    // Reset held for three edges
    repeat (3) tick();
    check("rst_seg", 32'(seg0), 32'h7F);
    check("rst_dp",  32'(dp0),  32'h1);
    check("rst_dig", 32'(dig0), 32'h0);
    check("rst_fs",  32'(fs0),  32'h0);

    // 12:34:56 scan
    rst_n = 1'b1; hour = 8'h12; min = 8'h34; sec = 8'h56; en = 1'b1;
    tick();
    check("load_seg", 32'(seg0), 32'h7F);
    check("load_dig", 32'(dig0), 32'h0);
    check("load_fs",  32'(fs0),  32'h1);
    tick();
    check("s0_dig", 32'(dig0), 32'b000001);
    check("s0_seg", 32'(seg0), 32'b1111001);
    repeat (3) tick();
    check("s0_hold", 32'(dig0), 32'b000001);
    tick();
    check("s1_dig", 32'(dig0), 32'b000010);
    check("s1_seg", 32'(seg0), 32'b0100100);

    // Tear-free: minute changes during slot 1
    min = 8'h35;
    repeat (8) tick();
    check("tear_dig", 32'(dig0), 32'b001000);
    check("tear_seg", 32'(seg0), 32'b0011001);
    check("tear_dp",  32'(dp0),  32'h0);
    repeat (11) tick();
    check("wrap_fs", 32'(fs0), 32'h1);
    repeat (13) tick();
    check("new_seg", 32'(seg0), 32'b0010010);

    // Reset mid-frame
    rst_n = 1'b0;
    tick();
    check("mid_rst_seg", 32'(seg0), 32'h7F);
    check("mid_rst_dig", 32'(dig0), 32'h0);
    rst_n = 1'b1;

    // Invalid hour units shows a dash
    hour = 8'h1A;
    tick();
    repeat (5) tick();
    check("dash_seg", 32'(seg0), 32'b0111111);

    // Leading-zero blanking
    en = 1'b0; tick();
    hour = 8'h05; en = 1'b1;
    tick();
    tick();
    check("lz_blank", 32'(seg1), 32'h7F);
    check("lz_dig",   32'(dig1), 32'b000001);
    check("nolz_seg", 32'(seg0), 32'h40);

    // en drop mid slot 2
    repeat (9) tick();
    check("pre_drop_dig", 32'(dig0), 32'b000100);
    en = 1'b0;
    tick();
    check("drop_dig", 32'(dig0), 32'h0);
    en = 1'b1;
    tick();
    check("reload_fs", 32'(fs0), 32'h1);
    tick();
    check("restart_dig", 32'(dig0), 32'b000001);

    // Odd seconds keep the colon dark
    en = 1'b0; tick();
    sec = 8'h57; en = 1'b1;
    tick();
    repeat (5) tick();
    check("odd_dp", 32'(dp0), 32'h1);
    repeat (24) tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      en    = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) begin
        hour = rand_bcd(); min = rand_bcd(); sec = rand_bcd();
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
